conv_loop_sequencer: RTL and testbench
======================================

Name: conv_loop_sequencer

Overview:
- Drives the convolution dataflow control signals that the utilization monitor interface observes: `dataflow_en`, `conv_vld`, loop indices, weight and input-loader requests, and layer done.
- Steps an oc → ic → h → w loop nest for one 3x3, pad-1, stride-1 layer.
- Handshakes with the weight buffer and the input loader, and emits one output pixel per cycle unless stalled.
- Sits between the layer controller and the PE array.

Parameters:
- CNT_W, 16, width of dimension configs and loop indices.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- layer_start  in  1  one-cycle pulse; cfg_* sampled on this cycle.
- cfg_w  in  CNT_W  output width W.
- cfg_h  in  CNT_W  output height H.
- cfg_ic  in  CNT_W  input channels IC.
- cfg_oc  in  CNT_W  output channels OC.
- stall  in  1  PE-array backpressure; freezes RUN.
- weight_req  out  1  request weights for the current (oc,ic).
- weight_ack  in  1  weight load complete.
- input_loader_req  out  1  request input row for the current h.
- input_ack  in  1  input row loaded.
- dataflow_en  out  1  a pixel is issued this cycle.
- conv_vld  out  9  per-tap valid mask for the issued pixel.
- w_idx, h_idx, ic_idx, oc_idx  out  CNT_W each  indices of the current pixel.
- layer_done  out  1  one-cycle pulse at end of layer.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rstn=0): state=IDLE. All outputs 0, all indices 0, latched cfg cleared. Reset mid-layer aborts with no layer_done; the next layer_start is accepted normally.
- States: IDLE, LOAD_W, LOAD_IN, RUN, DONE. All outputs are registered or decoded from registered state.
- IDLE: on layer_start, latch cfg_* and clear indices.
  - If any cfg is 0 → DONE; no requests are issued.
  - Otherwise → LOAD_W.
  - layer_start in any state other than IDLE is ignored.
- LOAD_W: weight_req=1. When weight_req&weight_ack in the same cycle → LOAD_IN; weight_req is 0 the next cycle. Ack while the request is low is ignored.
- LOAD_IN: input_loader_req=1. When input_loader_req&input_ack → RUN.
- RUN:
  - dataflow_en = !stall.
  - conv_vld = tap mask when dataflow_en, else 0.
  - Indices advance only on issued cycles.
  - Tap (r,c), r,c∈{0,1,2}, bit r*3+c: valid iff 0 ≤ h+r−1 ≤ H−1 and 0 ≤ w+c−1 ≤ W−1. Use an unsigned compare with a CNT_W+1 guard bit.
- Advance after an issued pixel:
  - w<W−1: w++ and stay in RUN.
  - w=W−1, h<H−1: w=0, h++ → LOAD_IN.
  - Plane end, ic<IC−1: w=h=0, ic++ → LOAD_W.
  - ic=IC−1, oc<OC−1: ic=0, oc++ → LOAD_W.
  - All loops at their maximum → DONE.
- DONE: layer_done=1 for exactly one cycle, busy=1, then → IDLE.
- Latency: layer_start at cycle 0 → weight_req at cycle 1. With zero-wait acks, each row costs W+1 cycles and each (oc,ic) costs 1 + H·(W+1) cycles.
- Stall during LOAD_W/LOAD_IN has no effect. Stall in RUN holds indices, and conv_vld=0.

Decomposition:
- Package conv_seq_pkg holds:
  - the `seq_state_e` enum (IDLE, LOAD_W, LOAD_IN, RUN, DONE);
  - constants K=3, PAD=1, NTAP=9;
  - default CNT_W.
- One natural sub-module: conv_tap_mask, a combinational mapping from (w,h,W,H) to the 9-bit mask, unit-testable on its own.

Test Plan:
- W=2,H=2,IC=1,OC=1, acks tied 1, start at cycle 0:
  - weight_req at cycle 1, input_loader_req at cycles 2 and 5.
  - dataflow_en at cycles 3,4,6,7 with conv_vld 0x1B0, 0x0D8, 0x036, 0x01B.
  - layer_done at cycle 8, busy low at cycle 9.
- W=3,H=3 centre pixel (1,1) → conv_vld=0x1FF. W=1,H=1 → 0x010.
- IC=2,OC=2,W=H=1, acks 1 → 4 weight_req handshakes. (oc,ic) order (0,0),(0,1),(1,0),(1,1). 4 issued pixels, one layer_done.
- weight_ack delayed 5 cycles, then stall high 3 cycles mid-row:
  - weight_req held 6 cycles, single transfer.
  - During the stall, indices frozen and conv_vld=0; pixel count unchanged.
- cfg_w=0 → layer_done at cycle 1, no requests. layer_start pulsed during RUN → ignored, exactly one layer_done.
- rstn low during RUN → all outputs 0 immediately, no layer_done; a new start runs a full layer correctly.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution loop sequencer.
package conv_seq_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned K         = 3;
  localparam int unsigned PAD       = 1;
  localparam int unsigned NTAP      = K * K;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_IN = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/conv_tap_mask.sv
// Maps an output pixel position to the 3x3 tap-valid mask for a pad-1, stride-1 window.
module conv_tap_mask
  import conv_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] w,
  input  logic [CNT_W-1:0] h,
  input  logic [CNT_W-1:0] cfg_w,
  input  logic [CNT_W-1:0] cfg_h,
  output logic [NTAP-1:0]  mask_c
);

  localparam int unsigned GW = CNT_W + 1;

  logic [K-1:0] row_ok;
  logic [K-1:0] col_ok;

  // Guard bit turns a coordinate of -1 into a huge unsigned value that fails the bound.
  for (genvar r = 0; r < K; r++) begin : g_row
    assign row_ok[r] = (({1'b0, h} + GW'(r)) - GW'(PAD)) < {1'b0, cfg_h};
    assign col_ok[r] = (({1'b0, w} + GW'(r)) - GW'(PAD)) < {1'b0, cfg_w};
  end

  for (genvar r = 0; r < K; r++) begin : g_mask_r
    for (genvar c = 0; c < K; c++) begin : g_mask_c
      assign mask_c[r*K + c] = row_ok[r] & col_ok[c];
    end
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Steps the oc -> ic -> h -> w loop nest of one 3x3 layer, handshaking weight and input loads.
module conv_loop_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             layer_start,
  input  logic [CNT_W-1:0] cfg_w,
  input  logic [CNT_W-1:0] cfg_h,
  input  logic [CNT_W-1:0] cfg_ic,
  input  logic [CNT_W-1:0] cfg_oc,
  input  logic             stall,
  output logic             weight_req,
  input  logic             weight_ack,
  output logic             input_loader_req,
  input  logic             input_ack,
  output logic             dataflow_en,
  output logic [NTAP-1:0]  conv_vld,
  output logic [CNT_W-1:0] w_idx,
  output logic [CNT_W-1:0] h_idx,
  output logic [CNT_W-1:0] ic_idx,
  output logic [CNT_W-1:0] oc_idx,
  output logic             layer_done,
  output logic             busy
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] cfg_w_q;
  logic [CNT_W-1:0] cfg_h_q;
  logic [CNT_W-1:0] cfg_ic_q;
  logic [CNT_W-1:0] cfg_oc_q;
  logic [NTAP-1:0]  tap_mask_c;
  logic             issue_c;
  logic             cfg_zero_c;
  logic             last_w_c;
  logic             last_h_c;
  logic             last_ic_c;
  logic             last_oc_c;

  assign issue_c    = (state_q == RUN) && !stall;
  assign cfg_zero_c = (cfg_w == '0) || (cfg_h == '0) || (cfg_ic == '0) || (cfg_oc == '0);
  assign last_w_c   = (w_idx  == cfg_w_q  - CNT_W'(1));
  assign last_h_c   = (h_idx  == cfg_h_q  - CNT_W'(1));
  assign last_ic_c  = (ic_idx == cfg_ic_q - CNT_W'(1));
  assign last_oc_c  = (oc_idx == cfg_oc_q - CNT_W'(1));

  conv_tap_mask #(
    .CNT_W (CNT_W)
  ) u_tap_mask (
    .w      (w_idx),
    .h      (h_idx),
    .cfg_w  (cfg_w_q),
    .cfg_h  (cfg_h_q),
    .mask_c (tap_mask_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (layer_start) begin
          state_d = cfg_zero_c ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        if (weight_ack) begin
          state_d = LOAD_IN;
        end
      end
      LOAD_IN: begin
        if (input_ack) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall && last_w_c) begin
          if (!last_h_c) begin
            state_d = LOAD_IN;
          end else if (!(last_ic_c && last_oc_c)) begin
            state_d = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    weight_req       = 1'b0;
    input_loader_req = 1'b0;
    dataflow_en      = 1'b0;
    conv_vld         = '0;
    layer_done       = 1'b0;
    busy             = (state_q != IDLE);
    unique case (state_q)
      LOAD_W:  weight_req       = 1'b1;
      LOAD_IN: input_loader_req = 1'b1;
      RUN: begin
        dataflow_en = !stall;
        conv_vld    = stall ? '0 : tap_mask_c;
      end
      DONE:    layer_done       = 1'b1;
      default: ;
    endcase
  end

  // Config latch and loop counters; indices move only on issued pixels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      cfg_ic_q <= '0;
      cfg_oc_q <= '0;
      w_idx    <= '0;
      h_idx    <= '0;
      ic_idx   <= '0;
      oc_idx   <= '0;
    end else if ((state_q == IDLE) && layer_start) begin
      cfg_w_q  <= cfg_w;
      cfg_h_q  <= cfg_h;
      cfg_ic_q <= cfg_ic;
      cfg_oc_q <= cfg_oc;
      w_idx    <= '0;
      h_idx    <= '0;
      ic_idx   <= '0;
      oc_idx   <= '0;
    end else if (issue_c) begin
      if (!last_w_c) begin
        w_idx <= w_idx + CNT_W'(1);
      end else begin
        w_idx <= '0;
        if (!last_h_c) begin
          h_idx <= h_idx + CNT_W'(1);
        end else begin
          h_idx <= '0;
          if (!last_ic_c) begin
            ic_idx <= ic_idx + CNT_W'(1);
          end else if (!last_oc_c) begin
            ic_idx <= '0;
            oc_idx <= oc_idx + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench for conv_loop_sequencer: a loop-nest model predicts loads and pixels, a monitor checks them.
module tb_conv_loop_sequencer;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          layer_start = 1'b0;
  logic [CW-1:0] cfg_w = '0, cfg_h = '0, cfg_ic = '0, cfg_oc = '0;
  logic          stall = 1'b0;
  logic          weight_req, input_loader_req, dataflow_en, layer_done, busy;
  logic          weight_ack = 1'b0, input_ack = 1'b0;
  logic [8:0]    conv_vld;
  logic [CW-1:0] w_idx, h_idx, ic_idx, oc_idx;

  always #5 clk = ~clk;

  conv_loop_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .layer_start(layer_start),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_ic(cfg_ic), .cfg_oc(cfg_oc),
    .stall(stall), .weight_req(weight_req), .weight_ack(weight_ack),
    .input_loader_req(input_loader_req), .input_ack(input_ack),
    .dataflow_en(dataflow_en), .conv_vld(conv_vld),
    .w_idx(w_idx), .h_idx(h_idx), .ic_idx(ic_idx), .oc_idx(oc_idx),
    .layer_done(layer_done), .busy(busy)
  );

  typedef struct packed { logic [CW-1:0] oc, ic, h, w; logic [8:0] vld; } pix_t;
  typedef struct packed { logic [CW-1:0] oc, ic; } wld_t;

  pix_t          pq[$];
  wld_t          wq[$];
  logic [CW-1:0] hq[$];

  int errors = 0, checks = 0;
  int done_cnt = 0, exp_done = 0, pix_cnt = 0, wh_cnt = 0, wreq_cycles = 0, req_cycles = 0;
  int w_delay = 0, in_delay = 0, wcnt = 0, icnt = 0, stall_left = 0;
  bit rand_acks = 1'b0, rand_stall = 1'b0, start_pend = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced an event the model did not expect", name);
  endtask

  function automatic logic [127:0] outs();
    return 128'({weight_req, input_loader_req, dataflow_en, layer_done, busy, conv_vld,
                 w_idx, h_idx, ic_idx, oc_idx});
  endfunction

  // Reference: walk the loop nest and derive each tap from window coordinates.
  task automatic model(input int W, input int H, input int IC, input int OC);
    wld_t e;
    pix_t p;
    exp_done++;
    if (W == 0 || H == 0 || IC == 0 || OC == 0) return;
    for (int oc = 0; oc < OC; oc++)
      for (int ic = 0; ic < IC; ic++) begin
        e.oc = CW'(oc); e.ic = CW'(ic);
        wq.push_back(e);
        for (int h = 0; h < H; h++) begin
          hq.push_back(CW'(h));
          for (int w = 0; w < W; w++) begin
            p.oc = CW'(oc); p.ic = CW'(ic); p.h = CW'(h); p.w = CW'(w); p.vld = '0;
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++)
                if (h + r - 1 >= 0 && h + r - 1 < H && w + c - 1 >= 0 && w + c - 1 < W)
                  p.vld[r*3 + c] = 1'b1;
            pq.push_back(p);
          end
        end
      end
  endtask

  // One clock of stimulus: start pulse, delayed/random acks, stall.
  task automatic tick();
    @(posedge clk);
    #1;
    layer_start = start_pend;
    start_pend  = 1'b0;
    if (weight_req) begin
      wcnt++;
      weight_ack = (wcnt > w_delay);
    end else begin
      if (wcnt != 0 && rand_acks) w_delay = $urandom_range(0, 3);
      wcnt = 0;
      weight_ack = rand_acks ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (input_loader_req) begin
      icnt++;
      input_ack = (icnt > in_delay);
    end else begin
      if (icnt != 0 && rand_acks) in_delay = $urandom_range(0, 3);
      icnt = 0;
      input_ack = rand_acks ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (stall_left > 0) begin
      stall = 1'b1;
      stall_left--;
    end else begin
      stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic start_layer(input int W, input int H, input int IC, input int OC);
    cfg_w = CW'(W); cfg_h = CW'(H); cfg_ic = CW'(IC); cfg_oc = CW'(OC);
    model(W, H, IC, OC);
    start_pend = 1'b1;
    tick();
  endtask

  task automatic finish_layer(input int d0, input string name);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) tick();
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s: no layer_done within cycle budget", name);
    end
    repeat (3) tick();
    chk({name, "_done_count"}, 128'(done_cnt), 128'(exp_done));
    chk({name, "_drained"}, 128'(pq.size() + wq.size() + hq.size()), 128'(0));
  endtask

  task automatic run_layer(input int W, input int H, input int IC, input int OC, input string name);
    int d0 = done_cnt;
    start_layer(W, H, IC, OC);
    finish_layer(d0, name);
  endtask

  task automatic wait_pix(input int target);
    for (int i = 0; i < 200 && pix_cnt < target; i++) tick();
    if (pix_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_pix: pix_cnt=%0d required %0d", pix_cnt, target);
    end
  endtask

  // Monitor: pops expected loads/pixels whenever the DUT presents one.
  always @(negedge clk) begin
    wld_t e;
    pix_t p;
    if (rstn) begin
      if (weight_req) wreq_cycles++;
      if (weight_req || input_loader_req) req_cycles++;
      if (layer_done) done_cnt++;
      if (weight_req && weight_ack) begin
        wh_cnt++;
        if (wq.size() == 0) miss("weight_load");
        else begin
          e = wq.pop_front();
          chk("weight_load_oc_ic", 128'({oc_idx, ic_idx}), 128'(e));
        end
      end
      if (input_loader_req && input_ack) begin
        if (hq.size() == 0) miss("input_load");
        else chk("input_load_h", 128'(h_idx), 128'(hq.pop_front()));
      end
      if (dataflow_en) begin
        pix_cnt++;
        if (pq.size() == 0) miss("pixel");
        else begin
          p = pq.pop_front();
          chk("pixel", 128'({oc_idx, ic_idx, h_idx, w_idx, conv_vld}), 128'(p));
        end
      end else if (stall) begin
        chk("vld_while_stalled", 128'(conv_vld), 128'(0));
      end
    end
  end

  initial begin
    logic [13:0] exp_tr [1:9];
    logic [63:0] snap;
    int d0, p0, w0, r0, c0;

    repeat (2) tick();
    chk("reset_outputs", outs(), 128'(0));
    rstn = 1'b1;
    tick();

    // Cycle-accurate trace, W=H=2, zero-wait acks.
    exp_tr[1] = {5'b10001, 9'h000};
    exp_tr[2] = {5'b01001, 9'h000};
    exp_tr[3] = {5'b00101, 9'h1B0};
    exp_tr[4] = {5'b00101, 9'h0D8};
    exp_tr[5] = {5'b01001, 9'h000};
    exp_tr[6] = {5'b00101, 9'h036};
    exp_tr[7] = {5'b00101, 9'h01B};
    exp_tr[8] = {5'b00011, 9'h000};
    exp_tr[9] = {5'b00000, 9'h000};
    start_layer(2, 2, 1, 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("trace_cycle%0d", k),
          128'({weight_req, input_loader_req, dataflow_en, layer_done, busy, conv_vld}),
          128'(exp_tr[k]));
    end
    tick();
    chk("trace_done_count", 128'(done_cnt), 128'(exp_done));

    // Channel loops: 4 weight loads, 4 pixels.
    w0 = wh_cnt; p0 = pix_cnt;
    run_layer(1, 1, 2, 2, "ic2_oc2");
    chk("ic2_oc2_weight_loads", 128'(wh_cnt - w0), 128'(4));
    chk("ic2_oc2_pixels", 128'(pix_cnt - p0), 128'(4));

    run_layer(3, 3, 1, 1, "w3h3");
    run_layer(1, 1, 1, 1, "w1h1");

    // Slow weight ack, then a 3-cycle stall mid-row.
    w_delay = 5;
    w0 = wh_cnt; r0 = wreq_cycles; p0 = pix_cnt; d0 = done_cnt;
    start_layer(4, 1, 1, 1);
    wait_pix(p0 + 2);
    stall_left = 3;
    for (int s = 0; s < 3; s++) begin
      tick();
      @(negedge clk);
      chk($sformatf("stall%0d_quiet", s), 128'({dataflow_en, conv_vld}), 128'(0));
      if (s == 0) begin
        snap = {oc_idx, ic_idx, h_idx, w_idx};
        c0 = pix_cnt;
      end else begin
        chk($sformatf("stall%0d_idx_frozen", s), 128'({oc_idx, ic_idx, h_idx, w_idx}), 128'(snap));
      end
    end
    chk("stall_pix_count", 128'(pix_cnt), 128'(c0));
    finish_layer(d0, "slow_ack_stall");
    chk("slow_ack_req_cycles", 128'(wreq_cycles - r0), 128'(6));
    chk("slow_ack_transfers", 128'(wh_cnt - w0), 128'(1));
    w_delay = 0;

    // Zero-sized config: done next cycle, no requests.
    r0 = req_cycles; d0 = done_cnt;
    start_layer(0, 3, 1, 1);
    tick();
    @(negedge clk);
    chk("zero_cfg_done_cycle1", 128'({layer_done, weight_req, input_loader_req}), 128'(3'b100));
    finish_layer(d0, "zero_cfg");
    chk("zero_cfg_no_requests", 128'(req_cycles - r0), 128'(0));

    // layer_start while running must be ignored.
    d0 = done_cnt; p0 = pix_cnt;
    start_layer(3, 2, 1, 1);
    wait_pix(p0 + 2);
    cfg_w = CW'(5); cfg_h = CW'(5); cfg_ic = CW'(2); cfg_oc = CW'(2);
    start_pend = 1'b1;
    tick();
    finish_layer(d0, "start_in_run");
    repeat (20) tick();
    chk("start_in_run_single_done", 128'(done_cnt - d0), 128'(1));

    // Reset mid-layer aborts without layer_done.
    p0 = pix_cnt;
    start_layer(4, 3, 1, 1);
    wait_pix(p0 + 3);
    rstn = 1'b0;
    #1;
    chk("midrun_reset_outputs", outs(), 128'(0));
    pq.delete(); wq.delete(); hq.delete();
    exp_done--;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) tick();
    chk("midrun_reset_no_done", 128'(done_cnt), 128'(exp_done));
    run_layer(3, 2, 2, 1, "after_reset");

    // Randomized layers with random ack latency and stalls.
    rand_acks = 1'b1; rand_stall = 1'b1;
    for (int i = 0; i < 12; i++)
      run_layer($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(1, 3), $sformatf("rand%0d", i));
    rand_acks = 1'b0; rand_stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
